// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM among NUM_CH requesters.
// Define MEM_ARBITER_STALL_CNT_EN to add the saturating stall_cnt output.
module mem_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_we,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
  input  logic [NUM_CH*BE_W-1:0]   ch_be,
  output logic [NUM_CH-1:0]        ch_gnt,
  output logic [NUM_CH-1:0]        ch_rvalid,
  output logic [DATA_W-1:0]        ch_rdata,
  output logic [ADDR_W-1:0]        mem_address,
  output logic [DATA_W-1:0]        mem_data,
  output logic                     mem_wren,
  output logic [BE_W-1:0]          mem_byteena,
`ifdef MEM_ARBITER_STALL_CNT_EN
  output logic [31:0]              stall_cnt,
  input  logic [DATA_W-1:0]        mem_q
`else
  input  logic [DATA_W-1:0]        mem_q
`endif
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] gnt_idx, cand_idx;
  logic             gnt_any;
  logic             pend_valid_q, pend_valid_d;
  logic [PTR_W-1:0] pend_idx_q, pend_idx_d;

  // Grant search starts at rr_ptr_q and wraps; nothing is granted while reset is held.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    cand_idx = '0;
    ch_gnt   = '0;
    if (rst_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cand_idx = PTR_W'((32'(rr_ptr_q) + i) % NUM_CH);
        if (!gnt_any && ch_req[cand_idx]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_idx;
        end
      end
    end
    if (gnt_any) ch_gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    mem_byteena = '0;
    if (gnt_any) begin
      mem_address = ch_addr[gnt_idx*ADDR_W +: ADDR_W];
      mem_data    = ch_wdata[gnt_idx*DATA_W +: DATA_W];
      mem_wren    = ch_we[gnt_idx];
      mem_byteena = ch_we[gnt_idx] ? ch_be[gnt_idx*BE_W +: BE_W] : {BE_W{1'b1}};
    end
  end

  always_comb begin
    rr_ptr_d     = gnt_any ? PTR_W'((32'(gnt_idx) + 32'd1) % NUM_CH) : rr_ptr_q;
    pend_valid_d = gnt_any && !ch_we[gnt_idx];
    pend_idx_d   = gnt_idx;
  end

  // Read data returns one cycle after the grant; suppressed while reset is held.
  always_comb begin
    ch_rvalid = '0;
    ch_rdata  = '0;
    if (rst_n && pend_valid_q) begin
      ch_rvalid[pend_idx_q] = 1'b1;
      ch_rdata              = mem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_idx_q   <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      pend_valid_q <= pend_valid_d;
      pend_idx_q   <= pend_idx_d;
    end
  end

`ifdef MEM_ARBITER_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic        stall_hit;

  // One increment per cycle no matter how many channels are left waiting.
  always_comb begin
    stall_hit   = |(ch_req & ~ch_gnt);
    stall_cnt_d = stall_cnt_q;
    if (stall_hit && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: 2-channel instance with a RAM model and read scoreboard,
// plus a 4-channel instance for pointer wrap.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 2-channel instance
  logic [1:0]  req, we, gnt, rvalid;
  logic [15:0] addr;
  logic [63:0] wdata;
  logic [7:0]  be;
  logic [31:0] rdata, mem_data, mem_q;
  logic [7:0]  mem_address;
  logic        mem_wren;
  logic [3:0]  mem_byteena;

  // 4-channel instance
  logic [3:0]   req4, we4, gnt4, rvalid4;
  logic [31:0]  addr4;
  logic [127:0] wdata4;
  logic [15:0]  be4;
  logic [31:0]  rdata4, mem_data4;
  logic [31:0]  mem_q4 = 32'h0;
  logic [7:0]   mem_address4;
  logic         mem_wren4;
  logic [3:0]   mem_byteena4;

`ifdef MEM_ARBITER_STALL_CNT_EN
  logic [31:0] stall_cnt, stall_cnt4;
`endif

  mem_arbiter #(.NUM_CH(2), .ADDR_W(8), .DATA_W(32)) dut2 (
    .clk(clk), .rst_n(rst_n), .ch_req(req), .ch_we(we), .ch_addr(addr), .ch_wdata(wdata),
    .ch_be(be), .ch_gnt(gnt), .ch_rvalid(rvalid), .ch_rdata(rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
    .mem_byteena(mem_byteena),
`ifdef MEM_ARBITER_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .mem_q(mem_q)
  );

  mem_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(32)) dut4 (
    .clk(clk), .rst_n(rst_n), .ch_req(req4), .ch_we(we4), .ch_addr(addr4), .ch_wdata(wdata4),
    .ch_be(be4), .ch_gnt(gnt4), .ch_rvalid(rvalid4), .ch_rdata(rdata4),
    .mem_address(mem_address4), .mem_data(mem_data4), .mem_wren(mem_wren4),
    .mem_byteena(mem_byteena4),
`ifdef MEM_ARBITER_STALL_CNT_EN
    .stall_cnt(stall_cnt4),
`endif
    .mem_q(mem_q4)
  );

  // Synchronous byte-enabled RAM; contents initialised on the first reset edge.
  logic [31:0] ram [256];
  logic        ram_init = 1'b0;
  always @(posedge clk) begin
    if (!ram_init) begin
      for (int a = 0; a < 256; a++) ram[a] <= {4{8'(a)}};
      ram[8'h10] <= 32'hDEAD_BEEF;
      ram[8'h20] <= 32'hFFFF_FFFF;
      ram_init   <= 1'b1;
    end else begin
      if (mem_wren) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteena[b]) ram[mem_address][b*8 +: 8] <= mem_data[b*8 +: 8];
      end
      mem_q <= ram[mem_address];
    end
  end

  typedef struct packed {
    logic        v;
    logic        ch;
    logic [31:0] d;
  } ret_t;
  ret_t sb[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int k, input logic r, input logic w, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] b);
    req[k]            = r;
    we[k]             = w;
    addr[k*8 +: 8]    = a;
    wdata[k*32 +: 32] = d;
    be[k*4 +: 4]      = b;
  endtask

  // Call at a negedge: check grant and last cycle's return, queue this cycle's expectation.
  task automatic tick(input string tag, input logic [1:0] eg, input logic rd,
                      input logic [31:0] d);
    ret_t e;
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    check({tag, ".gnt"}, 64'(gnt), 64'(eg));
    check({tag, ".rvalid"}, 64'(rvalid), 64'(e.v ? (2'b01 << e.ch) : 2'b00));
    check({tag, ".rdata"}, 64'(rdata), 64'(e.v ? e.d : 32'h0));
    e.v  = rd && (eg != 2'b00);
    e.ch = eg[1];
    e.d  = d;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_checks(input string tag);
    check({tag, ".gnt"}, 64'(gnt), 64'h0);
    check({tag, ".wren"}, 64'(mem_wren), 64'h0);
    check({tag, ".rvalid"}, 64'(rvalid), 64'h0);
    check({tag, ".rdata"}, 64'(rdata), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0; be = '0;
    req4 = '0; we4 = '0; addr4 = '0; wdata4 = '0; be4 = '0;

    // Both channels request reads from reset onwards
    drv(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    drv(1, 1'b1, 1'b0, 8'h11, 32'h0, 4'h0);
    repeat (2) begin
      @(negedge clk);
      reset_checks("reset");
      @(posedge clk);
    end
    #1;
`ifdef MEM_ARBITER_STALL_CNT_EN
    check("stall_reset", 64'(stall_cnt), 64'h0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i % 2 == 0) tick("rr_alt", 2'b01, 1'b1, 32'hDEAD_BEEF);
      else            tick("rr_alt", 2'b10, 1'b1, 32'h1111_1111);
    end
`ifdef MEM_ARBITER_STALL_CNT_EN
    check("stall_six", 64'(stall_cnt), 64'd6);
`endif

    // Single read from ch0
    drv(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    check("rd.addr", 64'(mem_address), 64'h10);
    check("rd.wren", 64'(mem_wren), 64'h0);
    check("rd.be", 64'(mem_byteena), 64'hF);
    tick("rd", 2'b01, 1'b1, 32'hDEAD_BEEF);

    // Partial write from ch1, then read-after-write from ch0
    drv(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    drv(1, 1'b1, 1'b1, 8'h20, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    check("wr.addr", 64'(mem_address), 64'h20);
    check("wr.wren", 64'(mem_wren), 64'h1);
    check("wr.be", 64'(mem_byteena), 64'h3);
    check("wr.data", 64'(mem_data), 64'h1234_5678);
    tick("wr", 2'b10, 1'b0, 32'h0);
    drv(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    drv(0, 1'b1, 1'b0, 8'h20, 32'h0, 4'h0);
    @(negedge clk);
    check("raw.wren", 64'(mem_wren), 64'h0);
    check("raw.be", 64'(mem_byteena), 64'hF);
    tick("raw", 2'b01, 1'b1, 32'hFFFF_5678);
    drv(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    check("idle.addr", 64'(mem_address), 64'h0);
    check("idle.data", 64'(mem_data), 64'h0);
    check("idle.be", 64'(mem_byteena), 64'h0);
    check("idle.wren", 64'(mem_wren), 64'h0);
    tick("idle", 2'b00, 1'b0, 32'h0);

    // Read granted right before reset must not return; pointer restarts at 0
    drv(0, 1'b1, 1'b0, 8'h10, 32'h0, 4'h0);
    @(negedge clk);
    tick("pre_rst", 2'b01, 1'b1, 32'hDEAD_BEEF);
    rst_n = 1'b0;
    drv(1, 1'b1, 1'b0, 8'h11, 32'h0, 4'h0);
    repeat (2) begin
      @(negedge clk);
      reset_checks("mid_rst");
      @(posedge clk);
    end
    #1;
    rst_n = 1'b1;
    sb.delete();
`ifdef MEM_ARBITER_STALL_CNT_EN
    check("stall_rst2", 64'(stall_cnt), 64'h0);
`endif
    @(negedge clk);
    tick("post_rst", 2'b01, 1'b1, 32'hDEAD_BEEF);
    @(negedge clk);
    tick("post_rst2", 2'b10, 1'b1, 32'h1111_1111);
    drv(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    tick("drain", 2'b00, 1'b0, 32'h0);

`ifdef MEM_ARBITER_STALL_CNT_EN
    // Preload the counter just below saturation, then keep a channel stalled
    drv(0, 1'b1, 1'b1, 8'h30, 32'hA5A5_A5A5, 4'hF);
    drv(1, 1'b1, 1'b1, 8'h31, 32'h5A5A_5A5A, 4'hF);
    @(negedge clk);
    force dut2.stall_cnt_q = 32'hFFFF_FFFD;
    #1;
    release dut2.stall_cnt_q;
    tick("sat0", 2'b01, 1'b0, 32'h0);
    check("stall_fe", 64'(stall_cnt), 64'hFFFF_FFFE);
    @(negedge clk);
    tick("sat1", 2'b10, 1'b0, 32'h0);
    check("stall_ff", 64'(stall_cnt), 64'hFFFF_FFFF);
    @(negedge clk);
    tick("sat2", 2'b01, 1'b0, 32'h0);
    check("stall_hold", 64'(stall_cnt), 64'hFFFF_FFFF);
    drv(0, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    drv(1, 1'b0, 1'b0, 8'h00, 32'h0, 4'h0);
    @(negedge clk);
    tick("sat_drain", 2'b00, 1'b0, 32'h0);
`endif

    // 4 channels: move pointer to 2, then ch1/ch3 alternate across the wrap
    we4  = 4'hF;
    be4  = 16'hFFFF;
    req4 = 4'b0010;
    @(negedge clk);
    check("rr4.first", 64'(gnt4), 64'b0010);
    check("rr4.wren", 64'(mem_wren4), 64'h1);
    @(posedge clk);
    #1;
    req4 = 4'b1010;
    @(negedge clk);
    check("rr4.ptr2", 64'(gnt4), 64'b1000);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rr4.wrap", 64'(gnt4), 64'b0010);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rr4.again", 64'(gnt4), 64'b1000);
    @(posedge clk);
    #1;
    req4 = '0;
    @(negedge clk);
    check("rr4.idle", 64'(gnt4), 64'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
